// File: rtl/qam16_frame_sync.sv
// qam16_frame_sync: finds frame alignment on a repeating 4-nibble sync word
// in the recovered QAM16 symbol stream. It runs a SEARCH/VERIFY/LOCK
// acquisition loop with flywheel tolerance and, once locked, packs payload
// nibbles into bytes with a frame-start marker.
module qam16_frame_sync #(
  parameter logic [15:0] SYNC_WORD     = 16'hEB90,
  parameter int          FRAME_NIBBLES = 64,
  parameter int          LOCK_CONFIRM  = 2,
  parameter int          LOSS_THRESH   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bitsync,
  input  logic [3:0] din,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       frame_start,
  output logic       locked
);

  localparam int P     = FRAME_NIBBLES - 4;
  localparam int CNT_W = $clog2(FRAME_NIBBLES);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCK} state_t;

  state_t           state, state_nxt;
  logic [11:0]      sr;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       hit_cnt, hit_nxt;
  logic [2:0]       miss_cnt, miss_nxt;
  logic [3:0]       hi;

  logic [15:0]      nv;
  logic             match;
  logic             boundary;
  logic             payload_stb;

  // The compare window includes the nibble arriving on this strobe, so only
  // the newest three nibbles need to be kept between strobes.
  assign nv          = {sr, din};
  assign match       = (nv == SYNC_WORD);
  assign boundary    = (cnt == CNT_W'(FRAME_NIBBLES - 1));
  assign payload_stb = bitsync && (state == LOCK) && (cnt < CNT_W'(P));
  assign locked      = (state == LOCK);

  // Acquisition state, symbol history and frame counters advance on strobes only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SEARCH;
      sr       <= '0;
      cnt      <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      hit_cnt  <= hit_nxt;
      miss_cnt <= miss_nxt;
      if (bitsync) sr <= nv[11:0];
    end
  end

  // Next-state logic: SEARCH tests every strobe, VERIFY/LOCK only the boundary.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hit_nxt   = hit_cnt;
    miss_nxt  = miss_cnt;
    if (bitsync) begin
      cnt_nxt = boundary ? '0 : cnt + CNT_W'(1);
      unique case (state)
        SEARCH: begin
          if (match) begin
            state_nxt = VERIFY;
            cnt_nxt   = '0;
            hit_nxt   = 3'd1;
          end
        end
        VERIFY: begin
          if (boundary) begin
            if (match) begin
              hit_nxt = hit_cnt + 3'd1;
              if (hit_nxt == 3'(LOCK_CONFIRM)) begin
                state_nxt = LOCK;
                miss_nxt  = '0;
              end
            end else begin
              state_nxt = SEARCH;
              hit_nxt   = '0;
            end
          end
        end
        LOCK: begin
          if (boundary) begin
            if (match) begin
              miss_nxt = '0;
            end else begin
              // Flywheel: keep the assumed boundary until enough misses pile up.
              miss_nxt = miss_cnt + 3'd1;
              if (miss_nxt == 3'(LOSS_THRESH)) state_nxt = SEARCH;
            end
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  // Byte packer: even payload nibbles park in hi, odd ones complete a byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout        <= '0;
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
      hi          <= '0;
    end else begin
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
      if (payload_stb) begin
        if (!cnt[0]) begin
          hi <= din;
        end else begin
          dout        <= {hi, din};
          dout_valid  <= 1'b1;
          frame_start <= (cnt == CNT_W'(1));
        end
      end
    end
  end

endmodule

// File: tb/tb_qam16_frame_sync.sv
// Bench for qam16_frame_sync: frame table plus hand-written corner sequences,
// with a byte scoreboard fed as payload nibbles are driven.
module tb_qam16_frame_sync;

  localparam int FN = 64;
  localparam int P  = FN - 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       bitsync;
  logic [3:0] din;
  logic [7:0] dout;
  logic       dout_valid;
  logic       frame_start;
  logic       locked;

  always #5 clk = ~clk;

  qam16_frame_sync #(
    .SYNC_WORD    (16'hEB90),
    .FRAME_NIBBLES(FN),
    .LOCK_CONFIRM (2),
    .LOSS_THRESH  (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bitsync    (bitsync),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .frame_start(frame_start),
    .locked     (locked)
  );

  typedef struct {
    logic [15:0] sw;    // sync word sent at the head of this frame
    logic        pre;   // locked after the 3rd sync nibble
    logic        post;  // locked after the 4th sync nibble
    logic        emit;  // payload of this frame is expected on dout
  } frame_t;

  frame_t     tbl[10];
  logic [8:0] exp_q[$];   // {byte, frame_start}
  int         tests = 0;
  int         fails = 0;
  bit         rand_gaps = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // One clock; every output byte is scored against the scoreboard here.
  task automatic tick();
    logic [8:0] e;
    @(negedge clk);
    if (dout_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_byte: got dout=%0h frame_start=%0b, required no output",
                 dout, frame_start);
      end else begin
        e = exp_q.pop_front();
        chk("byte{dout,fs}", {23'd0, dout, frame_start}, {23'd0, e});
      end
    end else if (frame_start !== 1'b0) begin
      tests++;
      fails++;
      $display("FAIL frame_start_alone: got frame_start=%0b, required 0 without dout_valid",
               frame_start);
    end
  endtask

  function automatic int gapv();
    return rand_gaps ? int'($urandom_range(1, 7)) : 0;
  endfunction

  task automatic strobe(input logic [3:0] n, input int gap);
    bitsync = 1'b1;
    din     = n;
    tick();
    bitsync = 1'b0;
    for (int i = 0; i < gap; i++) tick();
  endtask

  task automatic send_frame(input frame_t f, input int npay);
    for (int i = 0; i < 4; i++) begin
      strobe(f.sw[15-4*i -: 4], gapv());
      if (i == 2) chk("locked_pre", 32'(locked), 32'(f.pre));
    end
    chk("locked_post", 32'(locked), 32'(f.post));
    for (int k = 0; k < npay; k++) begin
      if (f.emit && k[0]) exp_q.push_back({4'(k - 1), 4'(k), k == 1});
      strobe(4'(k), gapv());
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bitsync = 1'b0;
    din     = 4'h0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) strobe(4'h5, 0);
  endtask

  task automatic send_sync();
    strobe(4'hE, 0);
    strobe(4'hB, 0);
    strobe(4'h9, 0);
    strobe(4'h0, 0);
  endtask

  initial begin
    logic [3:0]  n;
    logic [15:0] lfsr;

    tbl[0] = '{16'hEB90, 1'b0, 1'b0, 1'b0};  // first sync: VERIFY
    tbl[1] = '{16'hEB90, 1'b0, 1'b1, 1'b1};  // confirming sync: LOCK
    tbl[2] = '{16'hEB90, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{16'hEB91, 1'b1, 1'b1, 1'b1};  // miss 1
    tbl[4] = '{16'hEB91, 1'b1, 1'b1, 1'b1};  // miss 2
    tbl[5] = '{16'hEB90, 1'b1, 1'b1, 1'b1};  // good sync clears misses
    tbl[6] = '{16'h0B90, 1'b1, 1'b1, 1'b1};  // miss 1
    tbl[7] = '{16'hEB9F, 1'b1, 1'b1, 1'b1};  // miss 2
    tbl[8] = '{16'h1B90, 1'b1, 1'b0, 1'b0};  // miss 3: lock lost
    tbl[9] = '{16'hEB90, 1'b0, 1'b0, 1'b0};  // back in SEARCH: VERIFY only

    // Reset state
    do_reset();
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_dout_valid", 32'(dout_valid), 32'h0);
    chk("rst_frame_start", 32'(frame_start), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);

    // 500 strobes of LFSR nibbles with no E/B/9/0 symbols
    lfsr = 16'hACE1;
    for (int i = 0; i < 500; i++) begin
      do begin
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        n    = lfsr[3:0];
      end while (n == 4'hE || n == 4'hB || n == 4'h9 || n == 4'h0);
      strobe(n, 0);
    end
    chk("noise_locked", 32'(locked), 32'h0);

    // Acquisition, flywheel tolerance and loss, driven from the frame table
    do_reset();
    for (int r = 0; r < 10; r++) send_frame(tbl[r], P);
    chk("table_queue_empty", 32'(exp_q.size()), 32'h0);

    // Early sync must not be used by VERIFY
    do_reset();
    send_sync();   // A: enter VERIFY
    fill(P - 10);
    send_sync();   // B: 10 nibbles early
    fill(P);       // boundary of A passes with no sync -> SEARCH
    send_sync();   // C: new VERIFY
    chk("early_sync_locked", 32'(locked), 32'h0);
    fill(P);
    send_sync();   // D: confirms C
    chk("realign_locked", 32'(locked), 32'h1);

    // Irregular bitsync spacing gives the same bytes
    do_reset();
    rand_gaps = 1'b1;
    for (int r = 0; r < 3; r++) send_frame(tbl[r], P);
    rand_gaps = 1'b0;
    chk("gaps_queue_empty", 32'(exp_q.size()), 32'h0);

    // Reset mid-payload while locked, then re-acquire with two new syncs
    do_reset();
    send_frame(tbl[0], P);
    send_frame(tbl[1], 21);
    rst = 1'b1;
    tick();
    chk("midrst_dout", 32'(dout), 32'h0);
    chk("midrst_dout_valid", 32'(dout_valid), 32'h0);
    chk("midrst_frame_start", 32'(frame_start), 32'h0);
    chk("midrst_locked", 32'(locked), 32'h0);
    rst = 1'b0;
    tick();
    send_frame(tbl[0], P);
    send_frame(tbl[1], P);
    for (int i = 0; i < 4; i++) tick();
    chk("final_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1);
  end

endmodule

// File: doc/qam16_frame_sync.md
Name: qam16_frame_sync

Overview:
- Sits directly downstream of the QAM16 receive de-mapper / differential decoder.
- Consumes the 4-bit recovered symbol stream, one nibble per bitsync strobe, and finds frame alignment on a repeating sync word.
- Uses a SEARCH/VERIFY/LOCK state machine with flywheel tolerance.
- Once locked, packs payload nibbles into bytes with a valid strobe and a frame-start marker for the downstream byte sink.

Parameters:
- SYNC_WORD, 16'hEB90: 4-nibble sync word; the first received nibble is the MSB nibble.
- FRAME_NIBBLES, 64: nibbles from the end of one sync word to the end of the next. Payload P = FRAME_NIBBLES-4. Must be even and ≥ 6.
- LOCK_CONFIRM, 2: consecutive correctly spaced sync words needed to enter LOCK. Range 2..7.
- LOSS_THRESH, 3: consecutive missed syncs in LOCK that drop back to SEARCH. Range 1..7.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous reset, active-high.
- bitsync, input, 1: symbol strobe, one clk wide. din is sampled only on clk edges where bitsync=1.
- din, input, 4: recovered symbol nibble from the differential decoder.
- dout, output, 8: payload byte; the first nibble of each pair is dout[7:4].
- dout_valid, output, 1: one-clk pulse, dout is valid.
- frame_start, output, 1: one-clk pulse, coincident with dout_valid for the first byte of each frame.
- locked, output, 1: high while in LOCK.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. rst has priority over every other event.
- Reset values:
  - dout=0, dout_valid=0, frame_start=0, locked=0
  - state=SEARCH, shift register sr=0, cnt=0, hit_cnt=0, miss_cnt=0, hi nibble=0
- Reset mid-frame discards all alignment. Outputs are 0 in the cycle after the rst edge.
- Strobe cycles (bitsync=1):
  - sr <= {sr[11:0],din}.
  - nv = {sr[11:0],din} is the compare value.
- Non-strobe cycles (bitsync=0): no state change, dout_valid=0, frame_start=0, dout holds its value.
- cnt counts strobes since the last sync boundary, range 0..FRAME_NIBBLES-1. Boundary check happens on the strobe with cnt==FRAME_NIBBLES-1, after which cnt wraps to 0. All other strobes increment cnt.
- SEARCH:
  - nv is compared on every strobe.
  - On a match: go to VERIFY, cnt<=0, hit_cnt<=1.
  - No outputs are produced.
- VERIFY, at the boundary check:
  - Match: hit_cnt++. If the incremented value equals LOCK_CONFIRM, go to LOCK with miss_cnt<=0.
  - Mismatch: go to SEARCH, hit_cnt<=0.
  - No payload output.
- LOCK, at the boundary check:
  - Match: miss_cnt<=0.
  - Mismatch: miss_cnt++. If the incremented value equals LOSS_THRESH, go to SEARCH. Otherwise stay in LOCK (flywheel: the assumed boundary is kept).
- locked is registered: it rises in the cycle after the confirming strobe and falls in the cycle after the loss strobe.
- Payload output, LOCK only, strobes with cnt=k, k=0..P-1:
  - Even k: hi<=din.
  - Odd k: dout<={hi,din} and dout_valid=1 in the following cycle. frame_start=1 additionally when k==1.
  - Strobes with k=P..P+3 carry the sync nibbles and produce no output.
- The payload following the confirming sync word is the first payload emitted.
- If LOCK exits mid-frame (only possible via rst), partial bytes are discarded.
- Latency: 1 clk from the strobe edge carrying the odd nibble to dout_valid.
- Irregular bitsync spacing has no effect; only strobe order matters.

Test Plan (defaults, P=60, 30 bytes/frame):
- Reset, then 500 strobes of LFSR nibbles containing no E,B,9,0 run → locked=0, dout_valid never asserted.
- Three frames, each E,B,9,0 then payload nibble k = k mod 16 → locked rises the cycle after the 4th strobe of the 2nd sync. Frame 2 payload yields 30 pulses: 8'h01 (frame_start=1), 8'h23, …, 8'hAB, with frame_start only on the first. Frame 1 yields no output.
- Sync, then a second sync 10 nibbles early with none at the correct position → state returns to SEARCH, and the early sync is not used by VERIFY. locked stays 0.
- While locked, corrupt 2 consecutive sync words → locked stays 1 and 30 bytes per frame continue. Corrupt 3 consecutive → locked falls the cycle after the 3rd boundary strobe and output stops.
- Same stream as the second scenario with bitsync gaps of 1–7 clks, randomized → byte sequence identical.
- rst pulsed mid-payload while locked → all outputs 0 next cycle. Re-acquisition requires 2 new sync words.
